axi_noc_resp_mem: RTL and testbench

AXI4 slave responder with a small internal memory. It is the far end of the NoC for the transaction-tester initiator, and lets that initiator's write/read traffic be closed in a loopback or NoC bench. Write channel and read channel each run a serialized state machine with one outstanding transaction per direction. Status counters report completed transactions and protocol errors.

---
 rtl/axi_noc_resp_mem.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_axi_noc_resp_mem.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_noc_resp_mem.sv
// AXI4 slave responder backed by a small word-addressed memory.
// Closes the write/read traffic of the NoC transaction-tester initiator:
// one outstanding transaction per direction, independent write and read
// state machines, and completion/error status counters.
module axi_noc_resp_mem #(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned MEM_DEPTH = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // AW channel
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [63:0]           awaddr,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    // W channel
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    // B channel
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bid,
    output logic [1:0]            bresp,
    // AR channel
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [63:0]           araddr,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    // R channel
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rid,
    output logic                  rlast,
    output logic [1:0]            rresp,
    // status
    output logic [31:0]           wr_done_cnt,
    output logic [31:0]           rd_done_cnt,
    output logic [15:0]           err_cnt
);

    localparam int unsigned WSTRB_W   = DATA_W / 8;
    localparam int unsigned ADDR_LSB  = $clog2(WSTRB_W);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(WSTRB_W);
    localparam logic [2:0]  BEAT_SIZE = 3'(ADDR_LSB);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Word storage; contents survive reset.
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Write-side state
    w_state_t          w_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [1:0]        bid_q, bresp_q;
    logic [IDX_W-1:0]  w_idx_q;
    logic [7:0]        w_len_q, w_cnt_q;
    logic [1:0]        w_burst_q;
    logic              w_bad_q;
    logic              w_over_q;   // beats are arriving past awlen

    // Read-side state
    r_state_t          r_state_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [1:0]        rid_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  r_idx_q;
    logic [7:0]        r_len_q, r_cnt_q;
    logic [1:0]        r_burst_q;
    logic              r_bad_q;

    // Status counters
    logic [31:0]       wr_done_q, wr_done_d;
    logic [31:0]       rd_done_q, rd_done_d;
    logic [15:0]       err_q, err_d;

    // Address decode: offset from the window base, word index, bad flag
    logic [63:0]       aw_off, ar_off;
    logic [IDX_W-1:0]  aw_idx, ar_idx;
    logic              aw_bad, ar_bad;

    assign aw_off = awaddr - BASE_ADDR;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_idx = aw_off[ADDR_LSB+IDX_W-1:ADDR_LSB];
    assign ar_idx = ar_off[ADDR_LSB+IDX_W-1:ADDR_LSB];
    // Unsigned subtraction makes addresses below the base wrap to huge offsets.
    assign aw_bad = (aw_off >= MEM_BYTES) || (awsize != BEAT_SIZE);
    assign ar_bad = (ar_off >= MEM_BYTES) || (arsize != BEAT_SIZE);

    // Handshake qualifiers
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire, r_last_fire;
    assign aw_fire     = (w_state_q == W_IDLE) && awvalid && awready_q;
    assign w_fire      = (w_state_q == W_DATA) && wvalid && wready_q;
    assign b_fire      = (w_state_q == W_RESP) && bvalid_q && bready;
    assign ar_fire     = (r_state_q == R_IDLE) && arvalid && arready_q;
    assign r_fire      = (r_state_q == R_DATA) && rvalid_q && rready;
    assign r_last_fire = r_fire && rlast_q;

    // A beat mismatches the announced length if wlast comes early or late,
    // or if any beat arrives once the burst should already have ended.
    logic w_at_len, w_mismatch, mem_we;
    assign w_at_len   = !w_over_q && (w_cnt_q == w_len_q);
    assign w_mismatch = wlast ? !w_at_len : (w_over_q || w_at_len);
    assign mem_we     = w_fire && !w_bad_q && !w_over_q;

    logic [IDX_W-1:0] r_next_idx;
    assign r_next_idx = (r_burst_q == BURST_FIXED) ? r_idx_q : r_idx_q + 1'b1;

    // Byte-masked memory write for accepted, in-range, well-formed beats
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(WSTRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: AW accept, W beat collection, B response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 2'b00;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_burst_q <= 2'b00;
            w_bad_q   <= 1'b0;
            w_over_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        bid_q     <= awid;
                        w_idx_q   <= aw_idx;
                        w_len_q   <= awlen;
                        w_cnt_q   <= 8'd0;
                        w_burst_q <= awburst;
                        w_bad_q   <= aw_bad;
                        w_over_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_burst_q != BURST_FIXED) begin
                            w_idx_q <= w_idx_q + 1'b1;
                        end
                        if (!w_over_q && !w_at_len) begin
                            w_cnt_q <= w_cnt_q + 8'd1;
                        end
                        if (!wlast && w_at_len) begin
                            w_over_q <= 1'b1;
                        end
                        if (w_mismatch) begin
                            w_bad_q <= 1'b1;
                        end
                        if (wlast) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (w_bad_q || w_mismatch) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: AR accept with first-word load, then one beat per R handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 2'b00;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_burst_q <= 2'b00;
            r_bad_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_q     <= arid;
                        rresp_q   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                        rdata_q   <= ar_bad ? '0 : mem[ar_idx];
                        rlast_q   <= (arlen == 8'd0);
                        r_idx_q   <= ar_idx;
                        r_len_q   <= arlen;
                        r_cnt_q   <= 8'd0;
                        r_burst_q <= arburst;
                        r_bad_q   <= ar_bad;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_idx_q <= r_next_idx;
                            rdata_q <= r_bad_q ? '0 : mem[r_next_idx];
                            r_cnt_q <= r_cnt_q + 8'd1;
                            rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Counter next-state; both sides may report an error on the same edge
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    always_comb begin
        wr_done_d = wr_done_q + (b_fire ? 32'd1 : 32'd0);
        rd_done_d = rd_done_q + (r_last_fire ? 32'd1 : 32'd0);
        err_inc   = {1'b0, b_fire && bresp_q[1]} + {1'b0, r_last_fire && rresp_q[1]};
        err_sum   = {1'b0, err_q} + {15'd0, err_inc};
        err_d     = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_done_q <= 32'd0;
            rd_done_q <= 32'd0;
            err_q     <= 16'd0;
        end else begin
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
        end
    end

    assign awready     = awready_q;
    assign wready      = wready_q;
    assign bvalid      = bvalid_q;
    assign bid         = bid_q;
    assign bresp       = bresp_q;
    assign arready     = arready_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign rid         = rid_q;
    assign rlast       = rlast_q;
    assign rresp       = rresp_q;
    assign wr_done_cnt = wr_done_q;
    assign rd_done_cnt = rd_done_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_axi_noc_resp_mem.sv
// Directed bench for axi_noc_resp_mem: a table of write-then-read-back
// transactions plus hand-written sequences for strobes, wrap-around,
// length errors and mid-burst reset.
module tb_axi_noc_resp_mem;

    localparam int DW = 512;
    localparam int SW = DW / 8;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           awvalid, awready;
    logic [63:0]    awaddr;
    logic [1:0]     awburst, awid;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic           wvalid, wready;
    logic [DW-1:0]  wdata;
    logic [SW-1:0]  wstrb;
    logic           wlast;
    logic           bvalid, bready;
    logic [1:0]     bid, bresp;
    logic           arvalid, arready;
    logic [63:0]    araddr;
    logic [1:0]     arburst, arid;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic           rvalid, rready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rid;
    logic           rlast;
    logic [1:0]     rresp;
    logic [31:0]    wr_done_cnt, rd_done_cnt;
    logic [15:0]    err_cnt;

    axi_noc_resp_mem #(.DATA_W(DW), .MEM_DEPTH(64), .BASE_ADDR(64'h0)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awburst(awburst),
        .awid(awid), .awlen(awlen), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arburst(arburst),
        .arid(arid), .arlen(arlen), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp),
        .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt), .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    int exp_err = 0;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [1:0]  id;
        logic [31:0] seed;
        logic [1:0]  resp;
        bit          bp;
    } vec_t;

    vec_t vt[6];

    function automatic logic [DW-1:0] pat(input logic [31:0] s);
        return {(DW/32){s}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no handshake within bound, expected one", nm);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_wr_done"}, DW'(wr_done_cnt), DW'(exp_wr));
        chk({tag, "_rd_done"}, DW'(rd_done_cnt), DW'(exp_rd));
        chk({tag, "_err_cnt"}, DW'(err_cnt), DW'(exp_err));
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [1:0] id, input logic [31:0] seed,
                            input logic [SW-1:0] strb, input int nbeats, input logic [1:0] exp_resp,
                            input bit bp);
        int n;
        bit stalled;
        bit done;
        logic [1:0] p_id, p_resp;
        @(negedge aclk);
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id;
        n = 0;
        while (!awready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout("aw_handshake");
        @(posedge aclk); #1 awvalid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            wvalid = 1'b1; wdata = pat(seed + 32'(k)); wstrb = strb; wlast = (k == nbeats - 1);
            @(negedge aclk);
            n = 0;
            while (!wready && n < 100) begin @(negedge aclk); n++; end
            if (n >= 100) timeout("w_handshake");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0; stalled = 1'b0; done = 1'b0; p_id = 2'b00; p_resp = 2'b00;
        while (!done && n < 200) begin
            @(negedge aclk);
            if (stalled) begin
                chk("b_stall_bid", DW'(bid), DW'(p_id));
                chk("b_stall_bresp", DW'(bresp), DW'(p_resp));
            end
            bready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bvalid && bready) begin
                chk("bid", DW'(bid), DW'(id));
                chk("bresp", DW'(bresp), DW'(exp_resp));
                done = 1'b1;
            end
            stalled = bvalid && !bready;
            p_id = bid; p_resp = bresp;
            n++;
        end
        if (!done) timeout("b_handshake");
        @(posedge aclk); #1 bready = 1'b0;
        exp_wr++;
        if (exp_resp != 2'b00) exp_err++;
        @(negedge aclk);
        chk_counters("wr");
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [1:0] id, input logic [31:0] seed,
                           input bit use_fixed, input logic [DW-1:0] fixed_exp,
                           input logic [1:0] exp_resp, input bit bp);
        int n;
        int k;
        bit stalled;
        logic [DW-1:0] p_data, e_data;
        logic [1:0] p_id, p_resp;
        logic p_last;
        @(negedge aclk);
        arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id;
        n = 0;
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        if (n >= 100) timeout("ar_handshake");
        @(posedge aclk); #1 arvalid = 1'b0;
        @(negedge aclk);
        chk("ar_to_rvalid", DW'(rvalid), DW'(1));
        k = 0; n = 0; stalled = 1'b0;
        p_data = '0; p_id = 2'b00; p_resp = 2'b00; p_last = 1'b0;
        while (k <= int'(len) && n < 400) begin
            if (n > 0) @(negedge aclk);
            if (stalled) begin
                chk("r_stall_rdata", rdata, p_data);
                chk("r_stall_rid", DW'(rid), DW'(p_id));
                chk("r_stall_rresp", DW'(rresp), DW'(p_resp));
                chk("r_stall_rlast", DW'(rlast), DW'(p_last));
            end
            rready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rvalid && rready) begin
                if (use_fixed) e_data = fixed_exp;
                else if (exp_resp != 2'b00) e_data = '0;
                else e_data = pat(seed + 32'(k));
                chk("rdata", rdata, e_data);
                chk("rid", DW'(rid), DW'(id));
                chk("rresp", DW'(rresp), DW'(exp_resp));
                chk("rlast", DW'(rlast), DW'(k == int'(len)));
                k++;
            end
            stalled = rvalid && !rready;
            p_data = rdata; p_id = rid; p_resp = rresp; p_last = rlast;
            n++;
        end
        if (k <= int'(len)) timeout("r_burst");
        @(posedge aclk); #1 rready = 1'b0;
        exp_rd++;
        if (exp_resp != 2'b00) exp_err++;
        @(negedge aclk);
        chk_counters("rd");
    endtask

    logic [DW-1:0] part_val;
    logic [SW-1:0] all_strb;

    initial begin
        // addr, len, burst, size, id, seed, resp, backpressure
        vt[0] = '{64'h40,  8'd3, 2'b01, 3'd6, 2'd1, 32'h100, 2'b00, 1'b0};
        vt[1] = '{64'h400, 8'd0, 2'b00, 3'd6, 2'd2, 32'h200, 2'b00, 1'b1};
        vt[2] = '{64'h800, 8'd1, 2'b10, 3'd6, 2'd3, 32'h300, 2'b00, 1'b1};
        vt[3] = '{64'hF80, 8'd3, 2'b01, 3'd6, 2'd2, 32'h500, 2'b00, 1'b1};
        vt[4] = '{64'h1000, 8'd1, 2'b01, 3'd6, 2'd0, 32'h600, 2'b10, 1'b0};
        vt[5] = '{64'hC0,  8'd0, 2'b01, 3'd5, 2'd1, 32'h700, 2'b10, 1'b1};

        all_strb = '1;
        part_val = {{(DW-8){1'b1}}, 8'h00};

        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awburst = '0; awid = '0; awlen = '0; awsize = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arburst = '0; arid = '0; arlen = '0; arsize = '0;
        rready = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_awready", DW'(awready), DW'(1));
        chk("rst_arready", DW'(arready), DW'(1));
        chk("rst_wready", DW'(wready), DW'(0));
        chk("rst_bvalid", DW'(bvalid), DW'(0));
        chk("rst_rvalid", DW'(rvalid), DW'(0));
        chk("rst_rlast", DW'(rlast), DW'(0));
        chk("rst_rdata", rdata, '0);
        chk_counters("rst");
        aresetn = 1'b1;
        @(negedge aclk);

        // Table: write a burst, then read the same burst back
        for (int i = 0; i < 6; i++) begin
            do_write(vt[i].addr, vt[i].len, vt[i].burst, vt[i].size, vt[i].id, vt[i].seed,
                     all_strb, int'(vt[i].len) + 1, vt[i].resp, vt[i].bp);
            do_read(vt[i].addr, vt[i].len, vt[i].burst, vt[i].size, vt[i].id, vt[i].seed,
                    1'b0, '0, vt[i].resp, vt[i].bp);
        end

        // Partial strobe: fill word 0 with ones, then clear only byte 0
        do_write(64'h0, 8'd0, 2'b01, 3'd6, 2'd0, 32'hFFFF_FFFF, all_strb, 1, 2'b00, 1'b0);
        do_write(64'h0, 8'd0, 2'b01, 3'd6, 2'd1, 32'h0, SW'(1), 1, 2'b00, 1'b0);
        do_read(64'h0, 8'd0, 2'b01, 3'd6, 2'd1, 32'h0, 1'b1, part_val, 2'b00, 1'b0);

        // Out-of-range write aliases word 0 by index but must not touch it
        do_write(64'h1000, 8'd0, 2'b01, 3'd6, 2'd3, 32'hDEAD, all_strb, 1, 2'b10, 1'b0);
        do_read(64'h0, 8'd0, 2'b01, 3'd6, 2'd2, 32'h0, 1'b1, part_val, 2'b00, 1'b0);

        // Early wlast (beat 1 of awlen=3) and a beat past awlen=0
        do_write(64'h100, 8'd3, 2'b01, 3'd6, 2'd2, 32'h77, all_strb, 2, 2'b10, 1'b0);
        do_write(64'h500, 8'd0, 2'b01, 3'd6, 2'd1, 32'h88, all_strb, 2, 2'b10, 1'b1);

        // Reset in the middle of a 4-beat read from word 62
        @(negedge aclk);
        arvalid = 1'b1; araddr = 64'hF80; arlen = 8'd3; arburst = 2'b01; arsize = 3'd6; arid = 2'd3;
        @(posedge aclk); #1 arvalid = 1'b0; rready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        chk("midrst_rvalid", DW'(rvalid), DW'(0));
        chk("midrst_rlast", DW'(rlast), DW'(0));
        chk("midrst_rdata", rdata, '0);
        chk("midrst_arready", DW'(arready), DW'(1));
        chk_counters("midrst");
        @(negedge aclk);
        aresetn = 1'b1; rready = 1'b0;
        @(negedge aclk);
        chk("postrst_arready", DW'(arready), DW'(1));
        chk("postrst_rvalid", DW'(rvalid), DW'(0));
        // Memory survives reset: words 62 and 63 still hold the table data
        do_read(64'hF80, 8'd1, 2'b01, 3'd6, 2'd0, 32'h500, 1'b0, '0, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
